// File: rtl/id_ex_operand_latch.sv
// id_ex_operand_latch
// Decode-to-execute pipeline register. Captures register-file read data and
// decoded fields. Bypasses same-cycle writeback data into the operands.
// Detects load-use hazards and inserts bubbles. Refreshes held operands from
// writeback while EX is stalled.
module id_ex_operand_latch #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 8,
    parameter int MEMREAD_BIT    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      In_Valid,
    input  logic                      Stall,
    input  logic                      Flush,
    input  logic [REG_ADDR_WIDTH-1:0] Read_Reg_Num_1,
    input  logic [REG_ADDR_WIDTH-1:0] Read_Reg_Num_2,
    input  logic                      Uses_Rs1,
    input  logic                      Uses_Rs2,
    input  logic [DATA_WIDTH-1:0]     Read_Data_1,
    input  logic [DATA_WIDTH-1:0]     Read_Data_2,
    input  logic [REG_ADDR_WIDTH-1:0] Rd,
    input  logic [DATA_WIDTH-1:0]     Imm,
    input  logic [DATA_WIDTH-1:0]     PC,
    input  logic [CTRL_WIDTH-1:0]     Ctrl,
    input  logic                      WB_RegWrite,
    input  logic [REG_ADDR_WIDTH-1:0] WB_Reg_Num,
    input  logic [DATA_WIDTH-1:0]     WB_Data,
    output logic                      Hazard_Stall,
    output logic                      Ex_Valid,
    output logic [DATA_WIDTH-1:0]     Ex_Operand_1,
    output logic [DATA_WIDTH-1:0]     Ex_Operand_2,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rs1,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rs2,
    output logic [REG_ADDR_WIDTH-1:0] Ex_Rd,
    output logic [DATA_WIDTH-1:0]     Ex_Imm,
    output logic [DATA_WIDTH-1:0]     Ex_PC,
    output logic [CTRL_WIDTH-1:0]     Ex_Ctrl,
    output logic [15:0]               Bubble_Count
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [CTRL_WIDTH-1:0]     CTRL_ZERO = {CTRL_WIDTH{1'b0}};
    localparam logic [15:0]               CNT_MAX   = 16'hFFFF;

    logic                      ex_valid_q, ex_valid_d;
    logic [DATA_WIDTH-1:0]     ex_op1_q, ex_op1_d;
    logic [DATA_WIDTH-1:0]     ex_op2_q, ex_op2_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_WIDTH-1:0]     ex_imm_q, ex_imm_d;
    logic [DATA_WIDTH-1:0]     ex_pc_q, ex_pc_d;
    logic [CTRL_WIDTH-1:0]     ex_ctrl_q, ex_ctrl_d;
    logic [15:0]               bubble_count_q, bubble_count_d;

    logic                      hazard_s;
    logic                      wb_hit_rs1_s;
    logic                      wb_hit_rs2_s;
    logic [DATA_WIDTH-1:0]     byp_op1_s;
    logic [DATA_WIDTH-1:0]     byp_op2_s;

    // Register zero reads as zero; a same-cycle writeback to a nonzero source
    // register wins over the stale register-file value.
    function automatic logic [DATA_WIDTH-1:0] bypass_operand(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic                      wb_we,
        input logic [REG_ADDR_WIDTH-1:0] wb_num,
        input logic [DATA_WIDTH-1:0]     wb_data
    );
        logic [DATA_WIDTH-1:0] result;
        if (rs == REG_ZERO) begin
            result = DATA_ZERO;
        end else if (wb_we && (wb_num == rs)) begin
            result = wb_data;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    // Operand bypass for the load path and load-use hazard detection
    always_comb begin
        byp_op1_s = bypass_operand(Read_Reg_Num_1, Read_Data_1, WB_RegWrite, WB_Reg_Num, WB_Data);
        byp_op2_s = bypass_operand(Read_Reg_Num_2, Read_Data_2, WB_RegWrite, WB_Reg_Num, WB_Data);
        wb_hit_rs1_s = WB_RegWrite && (WB_Reg_Num != REG_ZERO) && (WB_Reg_Num == ex_rs1_q);
        wb_hit_rs2_s = WB_RegWrite && (WB_Reg_Num != REG_ZERO) && (WB_Reg_Num == ex_rs2_q);
        hazard_s = In_Valid && ex_valid_q && ex_ctrl_q[MEMREAD_BIT] && (ex_rd_q != REG_ZERO) &&
                   ((Uses_Rs1 && (ex_rd_q == Read_Reg_Num_1)) ||
                    (Uses_Rs2 && (ex_rd_q == Read_Reg_Num_2)));
        Hazard_Stall = hazard_s || Stall;
    end

    // Next-state selection with priority flush, stall, hazard bubble, load
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_imm_d       = ex_imm_q;
        ex_pc_d        = ex_pc_q;
        ex_ctrl_d      = ex_ctrl_q;
        bubble_count_d = bubble_count_q;
        if (Flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_ZERO;
        end else if (Stall) begin
            if (wb_hit_rs1_s) begin
                ex_op1_d = WB_Data;
            end else begin
                ex_op1_d = ex_op1_q;
            end
            if (wb_hit_rs2_s) begin
                ex_op2_d = WB_Data;
            end else begin
                ex_op2_d = ex_op2_q;
            end
        end else if (hazard_s) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = CTRL_ZERO;
            if (bubble_count_q != CNT_MAX) begin
                bubble_count_d = bubble_count_q + 16'd1;
            end else begin
                bubble_count_d = bubble_count_q;
            end
        end else begin
            ex_valid_d = In_Valid;
            ex_op1_d   = byp_op1_s;
            ex_op2_d   = byp_op2_s;
            ex_rs1_d   = Read_Reg_Num_1;
            ex_rs2_d   = Read_Reg_Num_2;
            ex_rd_d    = Rd;
            ex_imm_d   = Imm;
            ex_pc_d    = PC;
            if (In_Valid) begin
                ex_ctrl_d = Ctrl;
            end else begin
                ex_ctrl_d = CTRL_ZERO;
            end
        end
    end

    // EX stage state registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_op1_q       <= DATA_ZERO;
            ex_op2_q       <= DATA_ZERO;
            ex_rs1_q       <= REG_ZERO;
            ex_rs2_q       <= REG_ZERO;
            ex_rd_q        <= REG_ZERO;
            ex_imm_q       <= DATA_ZERO;
            ex_pc_q        <= DATA_ZERO;
            ex_ctrl_q      <= CTRL_ZERO;
            bubble_count_q <= 16'h0000;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_imm_q       <= ex_imm_d;
            ex_pc_q        <= ex_pc_d;
            ex_ctrl_q      <= ex_ctrl_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign Ex_Valid     = ex_valid_q;
    assign Ex_Operand_1 = ex_op1_q;
    assign Ex_Operand_2 = ex_op2_q;
    assign Ex_Rs1       = ex_rs1_q;
    assign Ex_Rs2       = ex_rs2_q;
    assign Ex_Rd        = ex_rd_q;
    assign Ex_Imm       = ex_imm_q;
    assign Ex_PC        = ex_pc_q;
    assign Ex_Ctrl      = ex_ctrl_q;
    assign Bubble_Count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_operand_latch.sv
// Testbench for id_ex_operand_latch: reference model feeding a scoreboard of
// expected EX-stage contents, plus directed checks with literal expectations.
module tb_id_ex_operand_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, stall, flush, uses1, uses2, wb_we;
    logic [4:0]  rs1, rs2, rd, wb_num;
    logic [31:0] rd1, rd2, imm, pc, wb_data;
    logic [7:0]  ctrl;

    logic        hazard_stall, ex_valid;
    logic [31:0] ex_op1, ex_op2, ex_imm, ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [15:0] bubble_count;

    typedef struct {
        logic        valid;
        logic [31:0] op1, op2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [7:0]  ctrl;
        logic [15:0] cnt;
    } ex_state_t;

    ex_state_t m;
    ex_state_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_operand_latch dut (
        .clk(clk), .reset(reset), .In_Valid(in_valid), .Stall(stall), .Flush(flush),
        .Read_Reg_Num_1(rs1), .Read_Reg_Num_2(rs2), .Uses_Rs1(uses1), .Uses_Rs2(uses2),
        .Read_Data_1(rd1), .Read_Data_2(rd2), .Rd(rd), .Imm(imm), .PC(pc), .Ctrl(ctrl),
        .WB_RegWrite(wb_we), .WB_Reg_Num(wb_num), .WB_Data(wb_data),
        .Hazard_Stall(hazard_stall), .Ex_Valid(ex_valid), .Ex_Operand_1(ex_op1),
        .Ex_Operand_2(ex_op2), .Ex_Rs1(ex_rs1), .Ex_Rs2(ex_rs2), .Ex_Rd(ex_rd),
        .Ex_Imm(ex_imm), .Ex_PC(ex_pc), .Ex_Ctrl(ex_ctrl), .Bubble_Count(bubble_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input ex_state_t e);
        check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
        check_eq("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
        check_eq("bubble_count", {48'd0, bubble_count}, {48'd0, e.cnt});
        check_eq("ex_op1", {32'd0, ex_op1}, {32'd0, e.op1});
        check_eq("ex_op2", {32'd0, ex_op2}, {32'd0, e.op2});
        check_eq("ex_rs1", {59'd0, ex_rs1}, {59'd0, e.rs1});
        check_eq("ex_rs2", {59'd0, ex_rs2}, {59'd0, e.rs2});
        check_eq("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
        check_eq("ex_imm", {32'd0, ex_imm}, {32'd0, e.imm});
        check_eq("ex_pc", {32'd0, ex_pc}, {32'd0, e.pc});
    endtask

    task automatic model_reset();
        m.valid = 1'b0; m.op1 = 32'd0; m.op2 = 32'd0; m.imm = 32'd0; m.pc = 32'd0;
        m.rs1 = 5'd0; m.rs2 = 5'd0; m.rd = 5'd0; m.ctrl = 8'd0; m.cnt = 16'd0;
    endtask

    function automatic logic [31:0] model_src(input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return 32'd0;
        if (wb_we && wb_num == r) return wb_data;
        return d;
    endfunction

    function automatic logic model_hazard();
        return in_valid && m.valid && m.ctrl[0] && (m.rd != 5'd0) &&
               ((uses1 && m.rd == rs1) || (uses2 && m.rd == rs2));
    endfunction

    // One pipeline edge: check the combinational stall, predict, clock, compare.
    task automatic step();
        logic hz;
        #1;
        hz = model_hazard();
        check_eq("hazard_stall", {63'd0, hazard_stall}, {63'd0, hz || stall});
        if (flush) begin
            m.valid = 1'b0; m.ctrl = 8'd0;
        end else if (stall) begin
            if (wb_we && wb_num != 5'd0 && wb_num == m.rs1) m.op1 = wb_data;
            if (wb_we && wb_num != 5'd0 && wb_num == m.rs2) m.op2 = wb_data;
        end else if (hz) begin
            m.valid = 1'b0; m.ctrl = 8'd0;
            if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
        end else begin
            m.valid = in_valid;
            m.op1 = model_src(rs1, rd1);
            m.op2 = model_src(rs2, rd2);
            m.rs1 = rs1; m.rs2 = rs2; m.rd = rd; m.imm = imm; m.pc = pc;
            m.ctrl = in_valid ? ctrl : 8'd0;
        end
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            compare_all(exp_q.pop_front());
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0; uses1 = 1'b0; uses2 = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd1 = 32'd0; rd2 = 32'd0;
        imm = 32'd0; pc = 32'd0; ctrl = 8'd0; wb_we = 1'b0; wb_num = 5'd0; wb_data = 32'd0;
    endtask

    task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [7:0] c);
        in_valid = 1'b1; uses1 = 1'b1; uses2 = 1'b1;
        rs1 = s1; rs2 = s2; rd = d; rd1 = d1; rd2 = d2; ctrl = c;
        imm = {24'd0, c} + 32'h100; pc = pc + 32'd4;
    endtask

    initial begin
        ex_state_t zero_e;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        zero_e = m;
        #3;
        compare_all(zero_e);
        @(negedge clk);
        reset = 1'b0;

        // Plain load
        set_instr(5'd3, 5'd4, 5'd8, 32'd9, 32'd4, 8'h10);
        step();
        check_eq("load_op1", {32'd0, ex_op1}, 64'd9);
        check_eq("load_op2", {32'd0, ex_op2}, 64'd4);
        check_eq("load_valid", {63'd0, ex_valid}, 64'd1);

        // Writeback bypass, then the same through register zero
        set_instr(5'd5, 5'd2, 5'd9, 32'd0, 32'd7, 8'h20);
        wb_we = 1'b1; wb_num = 5'd5; wb_data = 32'h1234;
        step();
        check_eq("bypass_op1", {32'd0, ex_op1}, 64'h1234);
        set_instr(5'd0, 5'd2, 5'd9, 32'h55, 32'd7, 8'h20);
        wb_num = 5'd0;
        step();
        check_eq("bypass_x0", {32'd0, ex_op1}, 64'd0);
        wb_we = 1'b0;

        // Load-use: lw x6 in EX, add x7,x6,x1 decoding
        set_instr(5'd2, 5'd0, 5'd6, 32'd1, 32'd0, 8'h01);
        step();
        set_instr(5'd6, 5'd1, 5'd7, 32'd3, 32'd4, 8'h02);
        step();
        check_eq("bubble_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("bubble_ctrl", {56'd0, ex_ctrl}, 64'd0);
        check_eq("bubble_count1", {48'd0, bubble_count}, 64'd1);
        step();
        check_eq("after_bubble_rd", {59'd0, ex_rd}, 64'd7);
        check_eq("after_bubble_valid", {63'd0, ex_valid}, 64'd1);

        // Stall with writeback refresh of the held rs1 operand
        set_instr(5'd3, 5'd4, 5'd10, 32'h11, 32'h22, 8'h04);
        step();
        stall = 1'b1; wb_we = 1'b1; wb_num = 5'd3; wb_data = 32'hAA;
        set_instr(5'd12, 5'd13, 5'd14, 32'hDEAD, 32'hBEEF, 8'h08);
        step();
        step();
        check_eq("stall_refresh_op1", {32'd0, ex_op1}, 64'hAA);
        check_eq("stall_hold_rd", {59'd0, ex_rd}, 64'd10);
        stall = 1'b0; wb_we = 1'b0;

        // Flush and stall on the same edge
        set_instr(5'd1, 5'd2, 5'd11, 32'd5, 32'd6, 8'h44);
        step();
        flush = 1'b1; stall = 1'b1;
        step();
        check_eq("flush_valid", {63'd0, ex_valid}, 64'd0);
        check_eq("flush_ctrl", {56'd0, ex_ctrl}, 64'd0);
        flush = 1'b0; stall = 1'b0;

        // Asynchronous reset in the middle of a hazard cycle
        set_instr(5'd1, 5'd0, 5'd6, 32'd1, 32'd0, 8'h01);
        step();
        set_instr(5'd1, 5'd6, 5'd7, 32'd3, 32'd4, 8'h02);
        #2;
        check_eq("pre_reset_hazard", {63'd0, hazard_stall}, 64'd1);
        reset = 1'b1;
        #1;
        compare_all(zero_e);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        set_instr(5'd2, 5'd3, 5'd4, 32'h77, 32'h88, 8'h10);
        step();
        check_eq("post_reset_load", {32'd0, ex_op1}, 64'h77);

        // Saturation: preload the counter to its maximum, then force a hazard
        force dut.bubble_count_q = 16'hFFFF;
        #1;
        release dut.bubble_count_q;
        m.cnt = 16'hFFFF;
        set_instr(5'd2, 5'd0, 5'd6, 32'd1, 32'd0, 8'h01);
        step();
        set_instr(5'd6, 5'd1, 5'd7, 32'd3, 32'd4, 8'h02);
        step();
        check_eq("sat_count", {48'd0, bubble_count}, 64'hFFFF);
        check_eq("sat_bubble_valid", {63'd0, ex_valid}, 64'd0);

        // Random traffic through the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 7) != 0);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            uses1    = $urandom_range(0, 1) == 1;
            uses2    = $urandom_range(0, 1) == 1;
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            rd       = 5'($urandom_range(0, 7));
            rd1      = $urandom;
            rd2      = $urandom;
            imm      = $urandom;
            pc       = $urandom;
            ctrl     = 8'($urandom);
            wb_we    = $urandom_range(0, 1) == 1;
            wb_num   = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
